// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line blocks: controller state encoding,
// CRC7 polynomial and serial step, and the default response frame geometry.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RECEIVE    = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_CHECK      = 3'd4
    } rsp_state_t;

    // x^7 + x^3 + 1, MSB (x^6 term) is the feedback tap
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int WORD_W_DEF    = 8;
    localparam int RESP_BITS_DEF = 48;
    localparam int NCR_MAX_DEF   = 64;
    // trailing CRC7 + end bit, excluded from the CRC run
    localparam int CRC_TAIL_BITS = 8;
    // cycles the converter may lag after the last bit before the frame is dropped
    localparam int DRAIN_MAX     = 8;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator, shared by the command transmitter and the
// response receiver. clear wins over en.
module crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    // next CRC value: clear, advance one bit, or hold
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = crc7_step(crc_q, din);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cmd_rsp_ctrl.sv
// SD CMD-line response receiver. Waits for the start bit, clocks the frame
// through an external serial-to-parallel converter, assembles the words and
// validates framing and CRC7.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | waiting for rx_start; results and sticky flags held
//   WAIT_START | watching cmd_in for the start bit, NCR_MAX-cycle timeout
//   RECEIVE    | converter enabled, one frame bit per cycle
//   DRAIN      | all bits sent, waiting up to DRAIN_MAX cycles for last words
//   CHECK      | one cycle: framing and CRC check, resp_valid if clean
module cmd_rsp_ctrl
    import sd_cmd_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int RESP_BITS = RESP_BITS_DEF,
    parameter int NCR_MAX   = NCR_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_start,
    input  logic                 cmd_in,
    output logic                 sp_enable,
    output logic                 sp_reset,
    input  logic [WORD_W-1:0]    sp_data,
    input  logic                 sp_push,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    output logic                 timeout_err,
    output logic                 frame_err,
    output logic                 crc_err,
    output logic                 busy
);

    localparam int WORDS    = RESP_BITS / WORD_W;
    localparam int CRC_BITS = RESP_BITS - CRC_TAIL_BITS;
    localparam int BIT_W    = $clog2(RESP_BITS + 1);
    localparam int WRD_W    = $clog2(WORDS + 1);
    localparam int TMR_MAX  = (NCR_MAX > DRAIN_MAX) ? NCR_MAX : DRAIN_MAX;
    localparam int TMR_W    = $clog2(TMR_MAX);

    rsp_state_t           state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WRD_W-1:0]     word_cnt_q, word_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RESP_BITS-1:0] resp_data_q, resp_data_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 crc_err_q, crc_err_d;

    logic                 crc_clear;
    logic                 crc_en;
    logic [6:0]           crc_val;
    logic                 bad_frame;
    logic                 bad_crc;

    crc7_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .en    (crc_en),
        .din   (cmd_in),
        .crc   (crc_val)
    );

    // next-state, word assembly and converter control
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        timer_d       = timer_q;
        resp_data_d   = resp_data_q;
        resp_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        frame_err_d   = frame_err_q;
        crc_err_d     = crc_err_q;
        sp_enable     = 1'b0;
        sp_reset      = 1'b0;
        crc_clear     = 1'b0;
        bad_frame     = 1'b0;
        bad_crc       = 1'b0;

        // words beyond the frame length are dropped
        if (sp_push && (state_q == ST_RECEIVE || state_q == ST_DRAIN)
            && (word_cnt_q < WRD_W'(WORDS))) begin
            resp_data_d = {resp_data_q[RESP_BITS-WORD_W-1:0], sp_data};
            word_cnt_d  = word_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_start) begin
                    state_d       = ST_WAIT_START;
                    bit_cnt_d     = '0;
                    word_cnt_d    = '0;
                    timer_d       = TMR_W'(NCR_MAX - 1);
                    resp_data_d   = '0;
                    timeout_err_d = 1'b0;
                    frame_err_d   = 1'b0;
                    crc_err_d     = 1'b0;
                    crc_clear     = 1'b1;
                    sp_reset      = 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (!cmd_in) begin
                    // start bit must reach the converter on this very edge
                    sp_enable = 1'b1;
                    bit_cnt_d = BIT_W'(1);
                    state_d   = ST_RECEIVE;
                end else if (timer_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (bit_cnt_q < BIT_W'(RESP_BITS)) begin
                    sp_enable = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (word_cnt_d == WRD_W'(WORDS)) begin
                    state_d = ST_CHECK;
                end else begin
                    timer_d = TMR_W'(DRAIN_MAX - 1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (word_cnt_d == WRD_W'(WORDS)) begin
                    state_d = ST_CHECK;
                end else if (timer_q == '0) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_CHECK: begin
                bad_frame    = resp_data_q[RESP_BITS-1] | resp_data_q[RESP_BITS-2]
                               | ~resp_data_q[0];
                bad_crc      = (crc_val != resp_data_q[7:1]);
                frame_err_d  = bad_frame;
                crc_err_d    = bad_crc;
                resp_valid_d = ~bad_frame & ~bad_crc;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            sp_enable = 1'b0;
            sp_reset  = 1'b1;
        end
    end

    // bit_cnt is 0 throughout WAIT_START, so the start bit is CRC bit 0
    assign crc_en = sp_enable && (bit_cnt_q < BIT_W'(CRC_BITS));

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            timer_q       <= '0;
            resp_data_q   <= '0;
            resp_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_err_q   <= 1'b0;
            crc_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            timer_q       <= timer_d;
            resp_data_q   <= resp_data_d;
            resp_valid_q  <= resp_valid_d;
            timeout_err_q <= timeout_err_d;
            frame_err_q   <= frame_err_d;
            crc_err_q     <= crc_err_d;
        end
    end

    assign resp_data   = resp_data_q;
    assign resp_valid  = resp_valid_q;
    assign timeout_err = timeout_err_q;
    assign frame_err   = frame_err_q;
    assign crc_err     = crc_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_rsp_ctrl.sv
// Bench for cmd_rsp_ctrl: behavioural serial-to-parallel converter, directed
// response frames, and a scoreboard checked whenever the controller goes idle.
module tb_cmd_rsp_ctrl;

    localparam int WORD_W    = 8;
    localparam int RESP_BITS = 48;
    localparam int NCR_MAX   = 64;
    localparam int WORDS     = RESP_BITS / WORD_W;

    localparam logic [47:0] FA = 48'h08_0000_01AA_13;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_start = 1'b0;
    logic        cmd_in = 1'b1;
    logic        sp_enable;
    logic        sp_reset;
    logic [7:0]  sp_data = 8'h00;
    logic        sp_push = 1'b0;
    logic [47:0] resp_data;
    logic        resp_valid;
    logic        timeout_err;
    logic        frame_err;
    logic        crc_err;
    logic        busy;

    cmd_rsp_ctrl #(.WORD_W(WORD_W), .RESP_BITS(RESP_BITS), .NCR_MAX(NCR_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_start    (rx_start),
        .cmd_in      (cmd_in),
        .sp_enable   (sp_enable),
        .sp_reset    (sp_reset),
        .sp_data     (sp_data),
        .sp_push     (sp_push),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .timeout_err (timeout_err),
        .frame_err   (frame_err),
        .crc_err     (crc_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    int en_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sp_enable) en_cnt <= en_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // converter model: MSB-first shift while enabled, push each full word;
    // the last word can be held back last_dly cycles, or all pushes muted
    int          last_dly = 0;
    bit          mute = 1'b0;
    logic [7:0]  cv_sr = 8'h00;
    int          cv_bits = 0;
    int          cv_words = 0;
    bit          cv_pend = 1'b0;
    int          cv_pend_cnt = 0;
    logic [7:0]  cv_pend_data = 8'h00;

    always @(posedge clk) begin
        sp_push <= 1'b0;
        if (sp_reset) begin
            cv_sr    = 8'h00;
            cv_bits  = 0;
            cv_words = 0;
            cv_pend  = 1'b0;
        end else begin
            if (cv_pend) begin
                if (cv_pend_cnt == 1) begin
                    sp_push <= !mute;
                    sp_data <= cv_pend_data;
                    cv_pend = 1'b0;
                end else begin
                    cv_pend_cnt--;
                end
            end
            if (sp_enable) begin
                cv_sr = {cv_sr[6:0], cmd_in};
                cv_bits++;
                if (cv_bits == WORD_W) begin
                    cv_bits = 0;
                    if (cv_words == WORDS - 1 && last_dly > 0) begin
                        cv_pend      = 1'b1;
                        cv_pend_cnt  = last_dly;
                        cv_pend_data = cv_sr;
                    end else begin
                        sp_push <= !mute;
                        sp_data <= cv_sr;
                    end
                    cv_words++;
                end
            end
        end
    end

    typedef struct {
        logic [47:0] data;
        logic        v;
        logic        t;
        logic        f;
        logic        c;
        int          lat;
        int          bits;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk(input logic [47:0] data, input logic v, input logic t,
                                input logic f, input logic c, input int lat, input int bits);
        exp_t e;
        e.data = data; e.v = v; e.t = t; e.f = f; e.c = c; e.lat = lat; e.bits = bits;
        return e;
    endfunction

    // monitor: every return to idle must match the oldest expectation
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: idle at cycle %0d with no expected entry", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("resp_valid",  64'(resp_valid),  64'(e.v));
                chk("resp_data",   64'(resp_data),   64'(e.data));
                chk("timeout_err", 64'(timeout_err), 64'(e.t));
                chk("frame_err",   64'(frame_err),   64'(e.f));
                chk("crc_err",     64'(crc_err),     64'(e.c));
                chk("latency",     64'(cyc - start_cyc), 64'(e.lat));
                chk("enable_bits", 64'(en_cnt),      64'(e.bits));
            end
        end else if (resp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_valid: resp_valid=1 at cycle %0d, expected 0", cyc);
        end
        prev_busy = busy;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_bound", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // issue rx_start, idle d cycles, then send frame f one bit per cycle;
    // optionally pulse reset or a second rx_start at a given bit index
    task automatic run_frame(input logic [47:0] f, input int d, input int rst_at,
                             input int again_at, input exp_t e);
        sb_q.push_back(e);
        rx_start  = 1'b1;
        start_cyc = cyc;
        en_cnt    = 0;
        @(negedge clk);
        rx_start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("flags_clr_on_start", 64'({timeout_err, frame_err, crc_err}), 64'd0);
        repeat (d - 1) @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            cmd_in = f[47-i];
            if (i == rst_at)   reset = 1'b1;
            if (i == again_at) rx_start = 1'b1;
            @(negedge clk);
            reset    = 1'b0;
            rx_start = 1'b0;
            if (i == rst_at) break;
        end
        cmd_in = 1'b1;
        wait_idle();
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sp_reset",  64'(sp_reset),  64'd1);
        chk("rst_sp_enable", 64'(sp_enable), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_data",  64'(resp_data), 64'd0);
        chk("rst_flags",      64'({resp_valid, timeout_err, frame_err, crc_err}), 64'd0);
        chk("idle_sp_reset",  64'(sp_reset),  64'd0);

        // clean R7 frame, start bit 3 cycles after rx_start
        run_frame(FA, 3, -1, -1, mk(FA, 1, 0, 0, 0, 53, 48));

        // no start bit: timeout after NCR_MAX cycles in WAIT_START
        sb_q.push_back(mk(48'h0, 0, 1, 0, 0, 1 + NCR_MAX, 0));
        rx_start  = 1'b1;
        start_cyc = cyc;
        en_cnt    = 0;
        @(negedge clk);
        rx_start = 1'b0;
        repeat (NCR_MAX - 2) @(negedge clk);
        chk("timeout_not_early", 64'({busy, timeout_err}), 64'b10);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("timeout_sticky", 64'({busy, timeout_err}), 64'b01);

        // CRC field 0x0A
        run_frame(48'h08_0000_01AA_15, 3, -1, -1, mk(48'h08_0000_01AA_15, 0, 0, 0, 1, 53, 48));

        // end bit 0, flag sticky, then cleared by the next accepted rx_start
        run_frame(48'h08_0000_01AA_12, 3, -1, -1, mk(48'h08_0000_01AA_12, 0, 0, 1, 0, 53, 48));
        repeat (4) @(negedge clk);
        chk("frame_err_sticky", 64'(frame_err), 64'd1);
        chk("resp_data_hold",   64'(resp_data), 64'h08_0000_01AA_12);
        run_frame(FA, 1, -1, -1, mk(FA, 1, 0, 0, 0, 51, 48));

        // direction bit set: framing and CRC both wrong, then CRC corrected
        run_frame(48'h48_0000_01AA_13, 2, -1, -1, mk(48'h48_0000_01AA_13, 0, 0, 1, 1, 52, 48));
        run_frame(48'h48_0000_01AA_87, 2, -1, -1, mk(48'h48_0000_01AA_87, 0, 0, 1, 0, 52, 48));

        // reset at bit 20 discards the frame, next frame is clean
        run_frame(FA, 3, 20, -1, mk(48'h0, 0, 0, 0, 0, 24, 20));
        run_frame(FA, 5, -1, -1, mk(FA, 1, 0, 0, 0, 55, 48));

        // rx_start while receiving is ignored
        run_frame(FA, 3, -1, 10, mk(FA, 1, 0, 0, 0, 53, 48));
        run_frame(FA, 3, -1, 47, mk(FA, 1, 0, 0, 0, 53, 48));

        // late last word: within and just past the drain window
        last_dly = 3;
        run_frame(FA, 3, -1, -1, mk(FA, 1, 0, 0, 0, 56, 48));
        last_dly = 8;
        run_frame(FA, 3, -1, -1, mk(FA, 1, 0, 0, 0, 61, 48));
        last_dly = 9;
        run_frame(FA, 3, -1, -1, mk(48'h00_0800_0001_AA, 0, 0, 1, 0, 60, 48));
        last_dly = 0;
        mute = 1'b1;
        run_frame(FA, 3, -1, -1, mk(48'h0, 0, 0, 1, 0, 60, 48));
        mute = 1'b0;

        run_frame(FA, 3, -1, -1, mk(FA, 1, 0, 0, 0, 53, 48));

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
